// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: PRBS7/15/23/31 pattern generator and self-synchronising
// checker for link and pad loopback testing.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset. Release is expected
//                   to arrive already synchronised to clk from the reset bridge.
//   en              advance the generator by one DATA_W-bit word this cycle
//   mode[1:0]       0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31
//   inj_err         request a single-bit error (MSB) in the next generated word
//   tx_data/tx_valid registered generated word, first-generated bit in MSB
//   rx_data/rx_valid received word to check, first bit in MSB
//   chk_clr         clear err_cnt and err_seen (lock state unaffected)
//   locked          checker is in LOCKED
//   err_cnt         saturating count of bit errors seen while locked
//   err_seen        sticky flag: an error was counted since reset/clear
module prbs_gen_chk #(
    parameter int DATA_W   = 8,
    parameter int ERR_W    = 16,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              inj_err,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              chk_clr,
    output logic              locked,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err_seen
);

    localparam int EW    = $clog2(DATA_W + 1);
    localparam int GW    = $clog2(LOCK_CNT + 1);
    localparam int BW    = $clog2(LOSS_CNT + 1);
    localparam int SUM_W = ((ERR_W > EW) ? ERR_W : EW) + 1;
    localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'({ERR_W{1'b1}});

    typedef enum logic {SEARCH, LOCKED} state_t;

    // All-ones seed for the selected length; doubles as the N-bit mask.
    function automatic logic [30:0] seed_of(input logic [1:0] m);
        case (m)
            2'd0:    return 31'h0000_007F;
            2'd1:    return 31'h0000_7FFF;
            2'd2:    return 31'h007F_FFFF;
            default: return 31'h7FFF_FFFF;
        endcase
    endfunction

    // Index of the oldest bit (N-1).
    function automatic logic [4:0] top_idx(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd6;
            2'd1:    return 5'd14;
            2'd2:    return 5'd22;
            default: return 5'd30;
        endcase
    endfunction

    // Index of the second tap (T-1).
    function automatic logic [4:0] tap_idx(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd5;
            2'd1:    return 5'd13;
            2'd2:    return 5'd17;
            default: return 5'd27;
        endcase
    endfunction

    // State
    logic [30:0]       gen_reg, gen_next;
    logic [30:0]       hist_reg, hist_next;
    logic [1:0]        mode_q_reg, mode_q_next;
    logic [DATA_W-1:0] tx_data_reg, tx_data_next;
    logic              tx_valid_reg, tx_valid_next;
    logic              inj_reg, inj_next;
    state_t            state_reg, state_next;
    logic [GW-1:0]     good_reg, good_next;
    logic [BW-1:0]     bad_reg, bad_next;
    logic [ERR_W-1:0]  err_reg, err_next;
    logic              seen_reg, seen_next;

    // Combinational word-wide stepping
    logic [4:0]        n_idx, t_idx;
    logic [30:0]       mask;
    logic [30:0]       gen_step, hist_step;
    logic [DATA_W-1:0] gen_word;
    logic [EW-1:0]     err_word;
    logic [SUM_W-1:0]  sum_ext;
    logic [ERR_W-1:0]  err_sat;
    logic              inj_pend;

    assign n_idx = top_idx(mode_q_reg);
    assign t_idx = tap_idx(mode_q_reg);
    assign mask  = seed_of(mode_q_reg);

    // Generator: DATA_W serial Fibonacci steps, first bit lands in the MSB.
    always_comb begin : gen_chain
        logic [30:0] g;
        logic        fb;
        g        = gen_reg;
        fb       = 1'b0;
        gen_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            fb                   = g[n_idx] ^ g[t_idx];
            gen_word[DATA_W-1-i] = fb;
            g                    = {g[29:0], fb} & mask;
        end
        gen_step = g;
    end

    // Checker: the history is built from received bits, so it resynchronises
    // to any phase of the sequence after N clean bits. A single line error
    // shows up three times: as itself, then at each tap as it shifts through.
    always_comb begin : chk_chain
        logic [30:0] h;
        logic        rx_bit;
        logic        mis;
        h        = hist_reg;
        rx_bit   = 1'b0;
        mis      = 1'b0;
        err_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rx_bit   = rx_data[DATA_W-1-i];
            mis      = h[n_idx] ^ h[t_idx] ^ rx_bit;
            err_word = err_word + EW'(mis);
            h        = {h[29:0], rx_bit} & mask;
        end
        hist_step = h;
    end

    // Sum is one bit wider than either operand so saturation never sees a wrap.
    assign sum_ext  = SUM_W'(err_reg) + SUM_W'(err_word);
    assign err_sat  = (sum_ext > ERR_MAX) ? {ERR_W{1'b1}} : sum_ext[ERR_W-1:0];
    assign inj_pend = inj_reg | inj_err;

    always_comb begin : next_state
        gen_next      = gen_reg;
        hist_next     = hist_reg;
        mode_q_next   = mode_q_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = 1'b0;
        inj_next      = inj_pend;
        state_next    = state_reg;
        good_next     = good_reg;
        bad_next      = bad_reg;
        err_next      = err_reg;
        seen_next     = seen_reg;

        if (mode != mode_q_reg) begin
            // Restart both halves on the new polynomial; this cycle's en and
            // rx word are dropped. Error totals survive the switch.
            mode_q_next = mode;
            gen_next    = seed_of(mode);
            hist_next   = '0;
            state_next  = SEARCH;
            good_next   = '0;
            bad_next    = '0;
        end else begin
            if (en) begin
                gen_next      = gen_step;
                tx_valid_next = 1'b1;
                // Injection touches only the output word, never the LFSR.
                tx_data_next  = gen_word ^ {inj_pend, {(DATA_W-1){1'b0}}};
                inj_next      = 1'b0;
            end

            if (rx_valid) begin
                hist_next = hist_step;
                case (state_reg)
                    SEARCH: begin
                        if (err_word != '0) begin
                            good_next = '0;
                        end else if (good_reg == GW'(LOCK_CNT - 1)) begin
                            good_next  = '0;
                            state_next = LOCKED;
                        end else begin
                            good_next = good_reg + GW'(1);
                        end
                    end
                    LOCKED: begin
                        // The word that drops lock is still counted.
                        err_next = err_sat;
                        if (err_word != '0) begin
                            seen_next = 1'b1;
                            if (bad_reg == BW'(LOSS_CNT - 1)) begin
                                bad_next   = '0;
                                state_next = SEARCH;
                            end else begin
                                bad_next = bad_reg + BW'(1);
                            end
                        end else begin
                            bad_next = '0;
                        end
                    end
                    default: state_next = SEARCH;
                endcase
            end
        end

        if (chk_clr) begin
            err_next  = '0;
            seen_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_reg      <= seed_of(mode);
            hist_reg     <= '0;
            mode_q_reg   <= mode;
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            inj_reg      <= 1'b0;
            state_reg    <= SEARCH;
            good_reg     <= '0;
            bad_reg      <= '0;
            err_reg      <= '0;
            seen_reg     <= 1'b0;
        end else begin
            gen_reg      <= gen_next;
            hist_reg     <= hist_next;
            mode_q_reg   <= mode_q_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
            inj_reg      <= inj_next;
            state_reg    <= state_next;
            good_reg     <= good_next;
            bad_reg      <= bad_next;
            err_reg      <= err_next;
            seen_reg     <= seen_next;
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
    assign locked   = (state_reg == LOCKED);
    assign err_cnt  = err_reg;
    assign err_seen = seen_reg;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: a vector table for the PRBS7 generator
// and injection timing, then hand-sequenced loopback scenarios for lock,
// injection, loss of lock, mode change, saturation (ERR_W=4 copy) and
// asynchronous reset. Inputs change and outputs are sampled on negedge.
module tb_prbs_gen_chk;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic        inj_err;
    logic        chk_clr;
    logic        rx_inv;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        locked;
    logic [15:0] err_cnt;
    logic        err_seen;

    logic [7:0]  tx_data4;
    logic        tx_valid4;
    logic        locked4;
    logic [3:0]  err_cnt4;
    logic        err_seen4;

    int checks;
    int failures;
    int nwords;

    // Loopback path, optionally inverted to force errors on every bit.
    assign rx_data  = rx_inv ? ~tx_data : tx_data;
    assign rx_valid = tx_valid;

    prbs_gen_chk #(.DATA_W(8), .ERR_W(16), .LOCK_CNT(8), .LOSS_CNT(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inj_err(inj_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .rx_data(rx_data),
        .rx_valid(rx_valid), .chk_clr(chk_clr), .locked(locked),
        .err_cnt(err_cnt), .err_seen(err_seen)
    );

    // Same stimulus, narrow counter to exercise saturation.
    prbs_gen_chk #(.DATA_W(8), .ERR_W(4), .LOCK_CNT(8), .LOSS_CNT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inj_err(inj_err),
        .tx_data(tx_data4), .tx_valid(tx_valid4), .rx_data(rx_data),
        .rx_valid(rx_valid), .chk_clr(chk_clr), .locked(locked4),
        .err_cnt(err_cnt4), .err_seen(err_seen4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // One clock; counts words the checker consumed on that edge.
    task automatic tick();
        logic v;
        v = rx_valid;
        @(negedge clk);
        if (v) nwords++;
    endtask

    task automatic wait_words(input int target);
        int k;
        k = 0;
        while (nwords < target && k < 200) begin
            tick();
            k++;
        end
        check("word_count", 32'(nwords), 32'(target));
    endtask

    typedef struct {
        logic       en;
        logic       inj;
        logic [7:0] exp_tx;
        logic       exp_v;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int bad;
        int wraps;
        logic [3:0] prev4;

        // PRBS7 from all-ones: words 0x02, 0x0C, 0x28, 0xF2, 0x2C, period 127.
        vecs[0] = '{1'b1, 1'b0, 8'h02, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 8'h0C, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 8'h0C, 1'b0};  // en low: hold, valid drops
        vecs[3] = '{1'b0, 1'b1, 8'h0C, 1'b0};  // request parked
        vecs[4] = '{1'b0, 1'b1, 8'h0C, 1'b0};  // second request collapses
        vecs[5] = '{1'b1, 1'b0, 8'hA8, 1'b1};  // 0x28 with MSB inverted
        vecs[6] = '{1'b1, 1'b1, 8'h72, 1'b1};  // same-cycle request: 0xF2 ^ 0x80
        vecs[7] = '{1'b1, 1'b0, 8'h2C, 1'b1};  // LFSR untouched by injection

        checks = 0; failures = 0; nwords = 0;
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; inj_err = 1'b0;
        chk_clr = 1'b0; rx_inv = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_tx_data",  32'(tx_data),  32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_locked",   32'(locked),   32'h0);
        check("rst_err_cnt",  32'(err_cnt),  32'h0);
        check("rst_err_seen", 32'(err_seen), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            en      = vecs[i].en;
            inj_err = vecs[i].inj;
            tick();
            check($sformatf("vec%0d_tx_data", i),  32'(tx_data),  32'(vecs[i].exp_tx));
            check($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(vecs[i].exp_v));
        end
        inj_err = 1'b0;
        en      = 1'b1;
        repeat (122) tick();   // words 6..127
        tick();
        check("prbs7_wrap_w128", 32'(tx_data), 32'h02);
        tick();
        check("prbs7_wrap_w129", 32'(tx_data), 32'h0C);

        // PRBS31 loopback from reset. Word 4 carries 3 mismatches while the
        // zeroed history meets the all-ones seed, so lock lands on word 12.
        en = 1'b0; mode = 2'd3; rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1; en = 1'b1; nwords = 0;
        wait_words(11);
        check("p31_not_locked_w11", 32'(locked), 32'h0);
        wait_words(12);
        check("p31_locked_w12", 32'(locked), 32'h1);
        check("p31_err_zero",   32'(err_cnt), 32'h0);

        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (err_cnt != 16'd0 || !locked) bad++;
        end
        check("soak_bad_samples", 32'(bad), 32'h0);

        // Single injection -> 3 mismatches, lock holds.
        inj_err = 1'b1; tick(); inj_err = 1'b0;
        repeat (8) tick();
        check("inj_err_cnt",  32'(err_cnt),  32'd3);
        check("inj_err_seen", 32'(err_seen), 32'h1);
        check("inj_locked",   32'(locked),   32'h1);
        check("inj_err_cnt4", 32'(err_cnt4), 32'd3);
        chk_clr = 1'b1; tick(); chk_clr = 1'b0;
        check("clr_err_cnt",  32'(err_cnt),  32'h0);
        check("clr_err_seen", 32'(err_seen), 32'h0);
        check("clr_locked",   32'(locked),   32'h1);

        // Inverted rx: 8+8+8 errors, then 5 on the 4th word which drops lock.
        rx_inv = 1'b1;
        repeat (3) tick();
        check("loss_err_cnt_w3", 32'(err_cnt), 32'd24);
        check("loss_locked_w3",  32'(locked),  32'h1);
        tick();
        check("loss_locked_w4",  32'(locked),   32'h0);
        check("loss_err_cnt_w4", 32'(err_cnt),  32'd29);
        check("loss_err_cnt4",   32'(err_cnt4), 32'd15);
        check("loss_err_seen",   32'(err_seen), 32'h1);

        // Restore: restored word 4 still mismatches, relock on word 12.
        rx_inv = 1'b0; nwords = 0;
        wait_words(11);
        check("relock_not_w11", 32'(locked), 32'h0);
        wait_words(12);
        check("relock_w12",     32'(locked),  32'h1);
        check("relock_err_cnt", 32'(err_cnt), 32'd29);

        // Mode 3 -> 1 with en held high.
        mode = 2'd1;
        tick();
        check("mode_tx_valid_gap", 32'(tx_valid), 32'h0);
        check("mode_locked_drop",  32'(locked),   32'h0);
        nwords = 0;
        tick();
        check("p15_w1_data",  32'(tx_data),  32'h00);
        check("p15_w1_valid", 32'(tx_valid), 32'h1);
        tick();
        check("p15_w2_data",  32'(tx_data),  32'h02);
        wait_words(9);
        check("p15_not_locked_w9", 32'(locked), 32'h0);
        wait_words(10);
        check("p15_locked_w10",    32'(locked),   32'h1);
        check("p15_err_cnt_kept",  32'(err_cnt),  32'd29);
        check("p15_err_seen_kept", 32'(err_seen), 32'h1);

        // chk_clr wins over the same-cycle count of the word carrying 2 errors.
        chk_clr = 1'b1; tick(); chk_clr = 1'b0;
        inj_err = 1'b1; tick(); inj_err = 1'b0;
        tick();
        check("prio_first_err", 32'(err_cnt), 32'd1);
        chk_clr = 1'b1; tick(); chk_clr = 1'b0;
        check("prio_clr_err_cnt",  32'(err_cnt),  32'h0);
        check("prio_clr_err_seen", 32'(err_seen), 32'h0);
        repeat (3) tick();
        check("prio_after_clr", 32'(err_cnt), 32'h0);

        // Injection every third word (never 4 errored words in a row):
        // 8 x 3 errors; the 4-bit counter must stop at 15.
        wraps = 0;
        prev4 = err_cnt4;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 3; k++) begin
                inj_err = (k == 0);
                tick();
                if (err_cnt4 < prev4) wraps++;
                prev4 = err_cnt4;
            end
        end
        inj_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (err_cnt4 < prev4) wraps++;
            prev4 = err_cnt4;
        end
        check("sat_wraps",    32'(wraps),    32'h0);
        check("sat_err_cnt4", 32'(err_cnt4), 32'd15);
        check("sat_err_cnt",  32'(err_cnt),  32'd24);
        check("sat_locked",   32'(locked),   32'h1);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_data",   32'(tx_data),  32'h0);
        check("arst_tx_valid",  32'(tx_valid), 32'h0);
        check("arst_locked",    32'(locked),   32'h0);
        check("arst_err_cnt",   32'(err_cnt),  32'h0);
        check("arst_err_seen",  32'(err_seen), 32'h0);
        check("arst_err_cnt4",  32'(err_cnt4), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_restart_data", 32'(tx_data), 32'h00);
        tick();
        check("arst_restart_w2",   32'(tx_data), 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
